// File: rtl/mem_write_checker_if.sv
// Store-checker bus: table programming, run control, monitored data-memory
// write port and verdict/capture outputs. clk/reset stay outside as plain ports.
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int IDX_W = $clog2(DEPTH + 1);

  // table programming and run control
  logic              exp_we;
  logic [IDX_W-1:0]  exp_idx;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [IDX_W-1:0]  num_exp;
  logic              start;

  // monitored store port
  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;

  // status and capture
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [IDX_W-1:0]  match_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic [31:0]       cycle_count;

  modport master (
    output exp_we, exp_idx, exp_addr, exp_data, num_exp, start,
    output MemWrite, DataAdr, WriteData,
    input  busy, done, pass, fail, timeout, match_count,
    input  fail_addr, fail_data, cycle_count
  );

  modport slave (
    input  exp_we, exp_idx, exp_addr, exp_data, num_exp, start,
    input  MemWrite, DataAdr, WriteData,
    output busy, done, pass, fail, timeout, match_count,
    output fail_addr, fail_data, cycle_count
  );
endinterface

// File: rtl/mem_write_checker.sv
// mem_write_checker: compares the CPU's data-memory stores, in order, against
// a programmable table of expected {address, data} pairs and reports
// pass / fail / timeout with capture of the offending store.
// Optional feature: define MWCHK_SCRATCH_EN to tolerate non-matching stores
// to SCRATCH_ADDR while running.
module mem_write_checker #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                DEPTH          = 4,
  parameter int                TIMEOUT_CYCLES = 1000,
  parameter logic [ADDR_W-1:0] SCRATCH_ADDR   = ADDR_W'(96)
) (
  input logic                clk,
  input logic                reset,
  mem_write_checker_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
  localparam logic [31:0]      TO_LAST = 32'(TIMEOUT_CYCLES - 1);

`ifdef MWCHK_SCRATCH_EN
  localparam logic SCRATCH_EN = 1'b1;
`else
  localparam logic SCRATCH_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W+DATA_W-1:0] exp_tbl [DEPTH];
  logic [IDX_W-1:0]  n_q;
  logic [IDX_W-1:0]  mc_q;
  logic [IDX_W-1:0]  mc_inc;
  logic [31:0]       cyc_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic              entry_eq;
  logic              scratch_hit;
  logic              hit;
  logic              capture;

  assign mc_inc      = mc_q + 1'b1;
  assign entry_eq    = ({bus.DataAdr, bus.WriteData} == exp_tbl[mc_q[AW-1:0]]);
  assign scratch_hit = SCRATCH_EN && (bus.DataAdr == SCRATCH_ADDR);

  // expected-table writes: IDLE only, in-range index only; never cleared
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_IDLE && bus.exp_we && bus.exp_idx < DEPTH_I)
      exp_tbl[bus.exp_idx[AW-1:0]] <= {bus.exp_addr, bus.exp_data};
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next state; a verdict from the store wins over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        if (n_q == '0) begin
          state_d = ST_PASS;
        end else if (bus.MemWrite && entry_eq) begin
          hit = 1'b1;
          if (mc_inc == n_q) state_d = ST_PASS;
        end else if (bus.MemWrite && !scratch_hit) begin
          capture = 1'b1;
          state_d = ST_FAIL;
        end
        if (state_d == ST_RUN && cyc_q == TO_LAST) state_d = ST_TIMEOUT;
      end
      default: ;
    endcase
  end

  // counters and capture registers; cycle_count freezes on the verdict cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q         <= '0;
      mc_q        <= '0;
      cyc_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (bus.start) begin
        n_q   <= (bus.num_exp > DEPTH_I) ? DEPTH_I : bus.num_exp;
        mc_q  <= '0;
        cyc_q <= '0;
      end
    end else if (state_q == ST_RUN) begin
      if (hit) mc_q <= mc_inc;
      if (capture) begin
        fail_addr_q <= bus.DataAdr;
        fail_data_q <= bus.WriteData;
      end
      if (state_d == ST_RUN && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
    end
  end

  // status decode from the registered state
  always_comb begin
    bus.busy    = (state_q == ST_RUN);
    bus.pass    = (state_q == ST_PASS);
    bus.fail    = (state_q == ST_FAIL);
    bus.timeout = (state_q == ST_TIMEOUT);
    bus.done    = bus.pass || bus.fail || bus.timeout;
  end

  assign bus.match_count = mc_q;
  assign bus.cycle_count = cyc_q;
  assign bus.fail_addr   = fail_addr_q;
  assign bus.fail_data   = fail_data_q;

endmodule
